// File: rtl/jive_uart_arb.sv
`timescale 1ns/1ps
// jive_uart_arb: round-robin arbiter sharing one jive UART slave port between two masters.
// The grant is locked until the slave acknowledges; a per-access watchdog ends silent accesses.
module jive_uart_arb #(
   parameter int TIMEOUT = 4095
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_csel,
   input  logic        m0_rden,
   input  logic        m0_wren,
   input  logic [3:0]  m0_bena,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_dtack,
   output logic        m0_tmo,
   input  logic        m1_csel,
   input  logic        m1_rden,
   input  logic        m1_wren,
   input  logic [3:0]  m1_bena,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_dtack,
   output logic        m1_tmo,
   output logic        s_csel,
   output logic        s_rden,
   output logic        s_wren,
   output logic [3:0]  s_bena,
   output logic [31:0] s_wdata,
   input  logic [31:0] s_rdata,
   input  logic        s_dtack
);

   localparam logic [11:0] TMO_LIM = 12'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t      state_r;
   logic        grant_r;
   logic        last_r;
   logic [11:0] cnt_r;

   logic        req0_s;
   logic        req1_s;
   logic        win_s;
   logic        g_csel_s;
   logic        g_rden_s;
   logic        g_wren_s;
   logic [3:0]  g_bena_s;
   logic [31:0] g_wdata_s;
   logic        req_g_s;
   logic        busy_s;
   logic        ack_s;
   logic        abort_s;
   logic        tmo_s;

   assign req0_s  = m0_csel & (m0_rden | m0_wren);
   assign req1_s  = m1_csel & (m1_rden | m1_wren);
   assign req_g_s = g_csel_s & (g_rden_s | g_wren_s);
   assign busy_s  = (state_r == ST_BUSY);
   assign ack_s   = busy_s & s_dtack;
   assign abort_s = busy_s & ~s_dtack & ~req_g_s;
   // A zero limit disables the watchdog; the acknowledge always beats expiry.
   assign tmo_s   = busy_s & ~s_dtack & req_g_s & (TMO_LIM != 12'd0) & (cnt_r == 12'd0);

   // Arbitration winner: a tie goes to the master not served last.
   always_comb begin
      win_s = 1'b0;
      if (req0_s && req1_s) begin
         win_s = ~last_r;
      end else if (req1_s) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
   end

   // Granted master's request fields.
   always_comb begin
      g_csel_s  = 1'b0;
      g_rden_s  = 1'b0;
      g_wren_s  = 1'b0;
      g_bena_s  = 4'h0;
      g_wdata_s = 32'h0;
      if (grant_r) begin
         g_csel_s  = m1_csel;
         g_rden_s  = m1_rden;
         g_wren_s  = m1_wren;
         g_bena_s  = m1_bena;
         g_wdata_s = m1_wdata;
      end else begin
         g_csel_s  = m0_csel;
         g_rden_s  = m0_rden;
         g_wren_s  = m0_wren;
         g_bena_s  = m0_bena;
         g_wdata_s = m0_wdata;
      end
   end

   // Arbitration FSM with grant lock and watchdog countdown.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         grant_r <= 1'b0;
         last_r  <= 1'b1;
         cnt_r   <= TMO_LIM;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req0_s || req1_s) begin
                  grant_r <= win_s;
                  cnt_r   <= TMO_LIM;
                  state_r <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (ack_s) begin
                  last_r  <= grant_r;
                  state_r <= ST_HOLD;
               end else if (abort_s) begin
                  last_r  <= grant_r;
                  state_r <= ST_IDLE;
               end else if (tmo_s) begin
                  last_r  <= grant_r;
                  state_r <= ST_HOLD;
               end else if (cnt_r != 12'd0) begin
                  cnt_r <= cnt_r - 12'd1;
               end
            end
            ST_HOLD: begin
               if (!g_csel_s) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Slave-side copy and master-side acknowledge forwarding, only while BUSY.
   always_comb begin
      s_csel   = 1'b0;
      s_rden   = 1'b0;
      s_wren   = 1'b0;
      s_bena   = 4'h0;
      s_wdata  = 32'h0;
      m0_rdata = 32'h0;
      m0_dtack = 1'b0;
      m0_tmo   = 1'b0;
      m1_rdata = 32'h0;
      m1_dtack = 1'b0;
      m1_tmo   = 1'b0;
      if (busy_s) begin
         s_csel  = g_csel_s;
         s_rden  = g_rden_s;
         s_wren  = g_wren_s;
         s_bena  = g_bena_s;
         s_wdata = g_wdata_s;
         if (grant_r) begin
            m1_dtack = ack_s | tmo_s;
            m1_tmo   = tmo_s;
            m1_rdata = ack_s ? s_rdata : 32'h0;
         end else begin
            m0_dtack = ack_s | tmo_s;
            m0_tmo   = tmo_s;
            m0_rdata = ack_s ? s_rdata : 32'h0;
         end
      end else begin
         s_csel = 1'b0;
      end
   end

endmodule
